// File: rtl/z2_bus_sequencer.sv
// z2_bus_sequencer: synchronises Zorro II strobes, claims the lowest-index decoded
// target and sequences DTACK (fixed wait states or target-ready) or a timeout BERR.
module z2_bus_sequencer #(
    parameter int NUM_TGT        = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int WS_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        AS_n,
    input  logic                        UDS_n,
    input  logic                        LDS_n,
    input  logic                        RW,
    input  logic [NUM_TGT-1:0]          tgt_sel,
    input  logic [NUM_TGT-1:0]          tgt_ready,
    input  logic [NUM_TGT-1:0]          tgt_fixed,
    input  logic [NUM_TGT*WS_WIDTH-1:0] tgt_ws,
    output logic                        as_s,
    output logic                        uds_s,
    output logic                        lds_s,
    output logic                        rw_s,
    output logic [2:0]                  state,
    output logic [NUM_TGT-1:0]          active_tgt,
    output logic                        claim,
    output logic                        dtack,
    output logic                        berr,
    output logic                        cycle_start,
    output logic                        cycle_end
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, ACK = 3'd3, TOUT = 3'd4} state_t;

    state_t                cur, nxt;
    logic [SYNC_STAGES-1:0] as_q, uds_q, lds_q, rw_q;
    logic [NUM_TGT-1:0]    act_n, sel_low;
    logic [WS_WIDTH-1:0]   ws_cnt, ws_n, ws_pick;
    logic [TW-1:0]         tcnt, t_n, t_inc;
    logic                  dtack_n, berr_n, cs_n, ce_n, fixed_m, rdy, done, to_hit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            as_q  <= '1;
            uds_q <= '1;
            lds_q <= '1;
            rw_q  <= '1;
        end else begin
            as_q  <= {as_q[SYNC_STAGES-2:0], AS_n};
            uds_q <= {uds_q[SYNC_STAGES-2:0], UDS_n};
            lds_q <= {lds_q[SYNC_STAGES-2:0], LDS_n};
            rw_q  <= {rw_q[SYNC_STAGES-2:0], RW};
        end
    end

    assign as_s  = as_q[SYNC_STAGES-1];
    assign uds_s = uds_q[SYNC_STAGES-1];
    assign lds_s = lds_q[SYNC_STAGES-1];
    assign rw_s  = rw_q[SYNC_STAGES-1];
    assign state = cur;
    assign claim = |active_tgt & ~as_s;

    // two's-complement trick isolates the lowest set bit of the decode
    assign sel_low = tgt_sel & (~tgt_sel + NUM_TGT'(1));
    assign fixed_m = |(active_tgt & tgt_fixed);
    assign rdy     = |(active_tgt & tgt_ready);
    assign done    = fixed_m ? (ws_cnt == '0) : rdy;
    assign t_inc   = (tcnt == '1) ? tcnt : tcnt + TW'(1);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (t_inc == T_LIM);

    always_comb begin
        ws_pick = '0;
        for (int i = 0; i < NUM_TGT; i++)
            if (sel_low[i]) ws_pick = tgt_ws[i*WS_WIDTH +: WS_WIDTH];
    end

    always_comb begin
        nxt     = cur;
        act_n   = active_tgt;
        ws_n    = ws_cnt;
        t_n     = tcnt;
        dtack_n = dtack;
        berr_n  = berr;
        cs_n    = 1'b0;
        ce_n    = 1'b0;
        case (cur)
            IDLE: begin
                dtack_n = 1'b0;
                berr_n  = 1'b0;
                if (!as_s && |tgt_sel) begin
                    act_n = sel_low;
                    ws_n  = ws_pick;
                    t_n   = '0;
                    cs_n  = 1'b1;
                    nxt   = START;
                end
            end
            START, DATA: begin
                t_n = t_inc;
                if (as_s) begin
                    nxt   = IDLE;
                    act_n = '0;
                    ce_n  = 1'b1;
                end else if (cur == DATA && done) begin
                    nxt     = ACK;
                    dtack_n = 1'b1;
                end else if (to_hit) begin
                    nxt    = TOUT;
                    berr_n = 1'b1;
                end else if (cur == START) begin
                    nxt = (!uds_s || !lds_s) ? DATA : START;
                end else if (fixed_m) begin
                    ws_n = ws_cnt - WS_WIDTH'(1);
                end
            end
            ACK, TOUT: begin
                if (as_s) begin
                    nxt     = IDLE;
                    act_n   = '0;
                    dtack_n = 1'b0;
                    berr_n  = 1'b0;
                    ce_n    = 1'b1;
                end
            end
            default: begin
                nxt     = IDLE;
                act_n   = '0;
                dtack_n = 1'b0;
                berr_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur         <= IDLE;
            active_tgt  <= '0;
            ws_cnt      <= '0;
            tcnt        <= '0;
            dtack       <= 1'b0;
            berr        <= 1'b0;
            cycle_start <= 1'b0;
            cycle_end   <= 1'b0;
        end else begin
            cur         <= nxt;
            active_tgt  <= act_n;
            ws_cnt      <= ws_n;
            tcnt        <= t_n;
            dtack       <= dtack_n;
            berr        <= berr_n;
            cycle_start <= cs_n;
            cycle_end   <= ce_n;
        end
    end
endmodule

// File: tb/tb_z2_bus_sequencer.sv
// tb_z2_bus_sequencer: directed vectors against three instances sharing stimulus:
// defaults (a_), TIMEOUT_CYCLES=8 (t_) and SYNC_STAGES=3 (s_).
module tb_z2_bus_sequencer;
    logic        CLK = 1'b0, RESET = 1'b1;
    logic        AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1;
    logic [4:0]  tgt_sel = '0, tgt_ready = '0, tgt_fixed = 5'b00110;
    logic [19:0] tgt_ws = '0;
    int          n_vec = 0, n_bad = 0;

    logic       a_as_s, a_uds_s, a_lds_s, a_rw_s, a_claim, a_dtack, a_berr, a_cs, a_ce;
    logic [2:0] a_state;
    logic [4:0] a_act;
    logic       t_as_s, t_uds_s, t_lds_s, t_rw_s, t_claim, t_dtack, t_berr, t_cs, t_ce;
    logic [2:0] t_state;
    logic [4:0] t_act;
    logic       s_as_s, s_uds_s, s_lds_s, s_rw_s, s_claim, s_dtack, s_berr, s_cs, s_ce;
    logic [2:0] s_state;
    logic [4:0] s_act;

    always #5 CLK = ~CLK;

    z2_bus_sequencer dut_a (
        .CLK(CLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .tgt_sel(tgt_sel), .tgt_ready(tgt_ready), .tgt_fixed(tgt_fixed), .tgt_ws(tgt_ws),
        .as_s(a_as_s), .uds_s(a_uds_s), .lds_s(a_lds_s), .rw_s(a_rw_s), .state(a_state),
        .active_tgt(a_act), .claim(a_claim), .dtack(a_dtack), .berr(a_berr),
        .cycle_start(a_cs), .cycle_end(a_ce));

    z2_bus_sequencer #(.TIMEOUT_CYCLES(8)) dut_t (
        .CLK(CLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .tgt_sel(tgt_sel), .tgt_ready(tgt_ready), .tgt_fixed(tgt_fixed), .tgt_ws(tgt_ws),
        .as_s(t_as_s), .uds_s(t_uds_s), .lds_s(t_lds_s), .rw_s(t_rw_s), .state(t_state),
        .active_tgt(t_act), .claim(t_claim), .dtack(t_dtack), .berr(t_berr),
        .cycle_start(t_cs), .cycle_end(t_ce));

    z2_bus_sequencer #(.SYNC_STAGES(3)) dut_s (
        .CLK(CLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .tgt_sel(tgt_sel), .tgt_ready(tgt_ready), .tgt_fixed(tgt_fixed), .tgt_ws(tgt_ws),
        .as_s(s_as_s), .uds_s(s_uds_s), .lds_s(s_lds_s), .rw_s(s_rw_s), .state(s_state),
        .active_tgt(s_act), .claim(s_claim), .dtack(s_dtack), .berr(s_berr),
        .cycle_start(s_cs), .cycle_end(s_ce));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        step(3);
        chk("rst_state", a_state, 0);
        chk("rst_syncs", {a_as_s, a_uds_s, a_lds_s, a_rw_s}, 4'hf);
        chk("rst_outs", {a_act, a_claim, a_dtack, a_berr, a_cs, a_ce}, 0);
        RESET = 1'b0;
        step(2);

        // fixed mode, target 2, ws=3; also SYNC_STAGES=3 latency on dut_s
        tgt_sel = 5'b00100;
        tgt_ws[8 +: 4] = 4'd3;
        AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b0;
        step(1);
        chk("fx_as_lat1", a_as_s, 1);
        step(1);
        chk("fx_as_s", a_as_s, 0);
        chk("fx_rw_s", a_rw_s, 0);
        chk("s3_as_p2", s_as_s, 1);
        step(1);
        chk("fx_start", a_state, 1);
        chk("fx_cstart", a_cs, 1);
        chk("fx_act", a_act, 5'b00100);
        chk("fx_claim", a_claim, 1);
        chk("s3_as_p3", s_as_s, 0);
        chk("s3_cs_p3", s_cs, 0);
        step(1);
        chk("fx_data", a_state, 2);
        chk("fx_cs_pulse", a_cs, 0);
        chk("s3_cs_p4", s_cs, 1);
        step(3);
        chk("fx_dtack_early", a_dtack, 0);
        step(1);
        chk("fx_dtack", a_dtack, 1);
        chk("fx_ack", a_state, 3);
        chk("fx_act_ack", a_act, 5'b00100);
        AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        step(2);
        chk("fx_dtack_hold", a_dtack, 1);
        chk("fx_claim_off", a_claim, 0);
        step(1);
        chk("fx_dtack_drop", a_dtack, 0);
        chk("fx_cend", a_ce, 1);
        chk("fx_idle", {a_state, a_act}, 0);
        step(1);
        chk("fx_cend_pulse", a_ce, 0);
        tgt_sel = '0;
        step(5);

        // priority and sel change after claim
        tgt_sel = 5'b10010;
        tgt_ws[4 +: 4] = 4'd2;
        AS_n = 1'b0; LDS_n = 1'b0;
        step(3);
        chk("pr_act", a_act, 5'b00010);
        tgt_sel = 5'b10000;
        step(1);
        chk("pr_act_hold", a_act, 5'b00010);
        step(3);
        chk("pr_dtack", a_dtack, 1);
        chk("pr_act_ack", a_act, 5'b00010);
        AS_n = 1'b1; LDS_n = 1'b1;
        step(3);
        tgt_sel = '0;
        step(5);

        // ready mode on target 0; dut_t times out meanwhile
        tgt_sel = 5'b00001;
        AS_n = 1'b0; UDS_n = 1'b0;
        step(3);
        chk("rd_start", a_state, 1);
        step(1);
        chk("rd_data", a_state, 2);
        step(1);
        tgt_ready = 5'b00010;
        step(2);
        tgt_ready = '0;
        step(1);
        chk("rd_other_ign", {a_dtack, a_state}, {1'b0, 3'd2});
        step(2);
        chk("to_before", {t_berr, t_state}, {1'b0, 3'd2});
        step(1);
        chk("to_berr", t_berr, 1);
        chk("to_state", t_state, 4);
        chk("to_no_dtack", t_dtack, 0);
        step(3);
        chk("rd_wait", a_dtack, 0);
        tgt_ready = 5'b00001;
        step(1);
        chk("rd_dtack", {a_dtack, a_berr, a_state}, {1'b1, 1'b0, 3'd3});
        chk("to_berr_hold", {t_dtack, t_berr}, 2'b01);
        AS_n = 1'b1; UDS_n = 1'b1; tgt_ready = '0;
        step(2);
        chk("rd_dtack_hold", a_dtack, 1);
        step(1);
        chk("rd_end", {a_dtack, a_ce, a_act}, {1'b0, 1'b1, 5'b0});
        chk("to_end", {t_berr, t_ce, t_state, t_act}, {1'b0, 1'b1, 3'd0, 5'b0});
        tgt_sel = '0;
        step(5);

        // ready coinciding with timeout: ACK wins
        tgt_sel = 5'b00001;
        AS_n = 1'b0; UDS_n = 1'b0;
        step(10);
        chk("tie_before", {t_dtack, t_berr, t_state}, {2'b00, 3'd2});
        tgt_ready = 5'b00001;
        step(1);
        chk("tie_ack", {t_dtack, t_berr, t_state}, {2'b10, 3'd3});
        AS_n = 1'b1; UDS_n = 1'b1; tgt_ready = '0;
        step(3);
        chk("tie_end", {t_ce, t_dtack, t_berr}, 3'b100);
        tgt_sel = '0;
        step(5);

        // abort from START
        tgt_sel = 5'b00001;
        AS_n = 1'b0;
        step(3);
        chk("ab_start", a_state, 1);
        AS_n = 1'b1;
        step(2);
        chk("ab_still", a_state, 1);
        step(1);
        chk("ab_idle", {a_state, a_act, a_dtack, a_berr}, 0);
        chk("ab_cend", a_ce, 1);
        tgt_sel = '0;
        step(5);

        // reset during ACK
        tgt_sel = 5'b00100;
        tgt_ws[8 +: 4] = 4'd0;
        AS_n = 1'b0; UDS_n = 1'b0;
        step(5);
        chk("rs_ack", {a_dtack, a_state}, {1'b1, 3'd3});
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1;
        step(1);
        chk("rs_state", a_state, 0);
        chk("rs_outs", {a_act, a_claim, a_dtack, a_berr, a_cs, a_ce}, 0);
        chk("rs_as_s", a_as_s, 1);
        RESET = 1'b0; tgt_sel = '0;
        step(1);
        chk("rs_no_cend", a_ce, 0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
